booth_div32x16_seq: RTL and testbench
=====================================

Name: booth_div32x16_seq

Overview:
- Sequential radix-2 restoring divider; the inverse of the 16x16 Booth multiplier datapath.
- Divides a 32-bit dividend by a 16-bit divisor, signed or unsigned.
- Returns a 16-bit quotient and 16-bit remainder with flags, over a start/busy/done handshake.
- Sits beside the multiplier in the ALU; one division in flight at a time.

Parameters:
- width, 32, dividend width. Divisor, quotient and remainder are width/2. Must be even and ≥4.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only when busy=0
- A  input  width  dividend
- B  input  width/2  divisor
- alu_signed  input  1  1 = two's-complement operands, 0 = unsigned
- busy  output  1  division in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- QUOT  output  width/2  quotient
- REM  output  width/2  remainder
- neg_flag  output  1  alu_signed & QUOT[MSB]
- zero_flag  output  1  QUOT == 0
- div_zero_flag  output  1  divisor was zero
- ovf_flag  output  1  true quotient does not fit width/2 bits

Behaviour:
- Reset: state=IDLE. busy, done, QUOT, REM and all flags are 0. Iteration counter is 0.
- rst mid-operation aborts immediately. No done pulse is produced.
- States: IDLE, RUN, FIX, DONE. busy=1 only in RUN and FIX.
- Accepting a request: start is accepted in IDLE or DONE at edge E0. start while busy is ignored; operands are not re-sampled.
- Operand capture at E0:
  - a_neg = alu_signed & A[MSB]; b_neg = alu_signed & B[MSB].
  - Magnitudes |A| (width bits, unsigned) and |B| (width/2 bits) are latched.
  - -2^31 → 0x80000000; -32768 → 0x8000.
- Divide-by-zero (B==0):
  - E0 → FIX; E1 → DONE.
  - Results: div_zero_flag=1, QUOT=all ones, REM=A[width/2-1:0], ovf_flag=0.
  - zero_flag=0; neg_flag = alu_signed.
- Normal path:
  - E0 → RUN.
  - RUN performs one restoring step per edge, E1..E32 (width steps):
    - shift {rem, q} left 1;
    - trial subtract |B| from the (width/2+1)-bit partial remainder;
    - keep the result if non-negative and set the q LSB.
  - Counter wraps to 0 at the last step; RUN → FIX at E32.
  - E33: FIX registers the outputs and enters DONE.
  - done=1 for exactly the cycle following E33 (latency 34 cycles from the start edge to the done cycle).
- Sign fix (FIX):
  - q_s = (a_neg^b_neg) ? -q_mag : q_mag.
  - r_s = a_neg ? -r_mag : r_mag. Truncating division: remainder takes the dividend's sign.
  - QUOT = q_s[width/2-1:0]; REM = r_s[width/2-1:0]. The remainder always fits.
- Overflow:
  - unsigned: ovf_flag = q_mag > 0xFFFF.
  - signed, positive result: ovf_flag = q_mag > 0x7FFF.
  - signed, negative result: ovf_flag = q_mag > 0x8000.
  - On overflow QUOT still equals the truncated low bits.
- Hold behaviour:
  - DONE lasts one cycle, then IDLE unless start is sampled.
  - Outputs and flags hold their values until the next accepted start's FIX.
  - Back-to-back operation: start in the DONE cycle begins a new operation at that edge.
- Flag computation: flags are computed from the registered QUOT in FIX, not combinationally from inputs.

Test Plan:
- Unsigned divide: A=0x000186A0, B=0x012C, alu_signed=0 → 34 cycles after start, done=1, QUOT=0x014D, REM=0x0064, all flags 0.
- Signed divide: A=0xFFFFFFF9 (-7), B=0x0002, alu_signed=1 → QUOT=0xFFFD, REM=0xFFFF, neg_flag=1, ovf_flag=0.
- Divide-by-zero: A=0x12345678, B=0x0000 → done 2 cycles after start, div_zero_flag=1, QUOT=0xFFFF, REM=0x5678.
- Overflow:
  - unsigned A=0x00010000, B=0x0001 → ovf_flag=1, QUOT=0x0000, zero_flag=1.
  - signed A=0x80000000, B=0xFFFF → ovf_flag=1, QUOT=0x0000, REM=0x0000.
  - signed A=0xFFFF8000, B=0x0001 → ovf_flag=0, QUOT=0x8000, neg_flag=1.
- Handshake:
  - start re-asserted with new operands at cycle 5 of a run → ignored; first result unchanged.
  - start held high in the DONE cycle → second result arrives 34 cycles later.
- Reset mid-run: rst at cycle 10 of a run → next cycle busy=0, outputs 0, no done pulse. A subsequent start completes normally.

Source files
------------

// File: rtl/booth_div32x16_seq.sv
// Sequential radix-2 restoring divider, width-bit dividend by width/2-bit divisor.
// Signed operands are divided as magnitudes and sign-corrected in a final FIX step.
`timescale 1ns/1ps
module booth_div32x16_seq #(
    parameter int width = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [width-1:0]   A,
    input  logic [width/2-1:0] B,
    input  logic               alu_signed,
    output logic               busy,
    output logic               done,
    output logic [width/2-1:0] QUOT,
    output logic [width/2-1:0] REM,
    output logic               neg_flag,
    output logic               zero_flag,
    output logic               div_zero_flag,
    output logic               ovf_flag
);
    localparam int H  = width / 2;
    localparam int CW = $clog2(width);
    localparam logic [width-1:0] HALF = {{(width-1){1'b0}}, 1'b1} << (H - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [width-1:0] q_q, q_d;
    logic [H-1:0]   rem_q, rem_d;
    logic [H-1:0]   bmag_q, bmag_d;
    logic           a_neg_q, a_neg_d;
    logic           b_neg_q, b_neg_d;
    logic           sgn_q, sgn_d;
    logic           dz_q, dz_d;
    logic [H-1:0]   quot_q, quot_d;
    logic [H-1:0]   remo_q, remo_d;
    logic           neg_q, neg_d;
    logic           zero_q, zero_d;
    logic           dzf_q, dzf_d;
    logic           ovf_q, ovf_d;

    logic             a_neg, b_neg;
    logic [width-1:0] a_mag;
    logic [H-1:0]     b_mag;
    logic [H:0]       shifted;
    logic             fits;
    logic [H-1:0]     sub;
    logic             q_negres;
    logic [H-1:0]     q_lo;
    logic [H-1:0]     r_lo;
    logic             ovf_calc;

    // Operand magnitudes at capture and one restoring step on the live state.
    assign a_neg    = alu_signed & A[width-1];
    assign b_neg    = alu_signed & B[H-1];
    assign a_mag    = a_neg ? -A : A;
    assign b_mag    = b_neg ? -B : B;
    assign shifted  = {rem_q, q_q[width-1]};
    assign fits     = shifted >= {1'b0, bmag_q};
    assign sub      = shifted[H-1:0] - bmag_q;
    assign q_negres = a_neg_q ^ b_neg_q;
    assign q_lo     = q_negres ? -q_q[H-1:0] : q_q[H-1:0];
    assign r_lo     = a_neg_q ? -rem_q : rem_q;

    // Quotient range check against the signed or unsigned result range.
    always_comb begin
        ovf_calc = 1'b0;
        if (!sgn_q)
            ovf_calc = q_q[width-1:H] != '0;
        else if (q_negres)
            ovf_calc = q_q > HALF;
        else
            ovf_calc = q_q >= HALF;
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rem_d   = rem_q;
        bmag_d  = bmag_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        sgn_d   = sgn_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        dzf_d   = dzf_q;
        ovf_d   = ovf_q;
        busy    = (state_q == RUN) || (state_q == FIX);
        done    = (state_q == DONE);
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_neg_d = a_neg;
                    b_neg_d = b_neg;
                    sgn_d   = alu_signed;
                    q_d     = a_mag;
                    bmag_d  = b_mag;
                    cnt_d   = '0;
                    dz_d    = (B == '0);
                    rem_d   = (B == '0) ? A[H-1:0] : '0;
                    state_d = (B == '0) ? FIX : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                q_d   = {q_q[width-2:0], fits};
                rem_d = fits ? sub : shifted[H-1:0];
                if (cnt_q == CW'(width - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                state_d = DONE;
                if (dz_q) begin
                    quot_d = '1;
                    remo_d = rem_q;
                    dzf_d  = 1'b1;
                    ovf_d  = 1'b0;
                    zero_d = 1'b0;
                    neg_d  = sgn_q;
                end else begin
                    quot_d = q_lo;
                    remo_d = r_lo;
                    dzf_d  = 1'b0;
                    ovf_d  = ovf_calc;
                    zero_d = (q_lo == '0);
                    neg_d  = sgn_q & q_lo[H-1];
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            bmag_q  <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            sgn_q   <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            dzf_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            bmag_q  <= bmag_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            sgn_q   <= sgn_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            dzf_q   <= dzf_d;
            ovf_q   <= ovf_d;
        end
    end

    assign QUOT          = quot_q;
    assign REM           = remo_q;
    assign neg_flag      = neg_q;
    assign zero_flag     = zero_q;
    assign div_zero_flag = dzf_q;
    assign ovf_flag      = ovf_q;
endmodule

// File: tb/tb_booth_div32x16_seq.sv
// Bench for booth_div32x16_seq: directed vectors, queue scoreboard,
// independent done monitor checking results and start-to-done latency.
`timescale 1ns/1ps
module tb_booth_div32x16_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [15:0] B = '0;
    logic        alu_signed = 1'b0;
    logic        busy, done;
    logic [15:0] QUOT, REM;
    logic        neg_flag, zero_flag, div_zero_flag, ovf_flag;
    logic [3:0]  flags;

    booth_div32x16_seq #(.width(32)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .alu_signed(alu_signed), .busy(busy), .done(done),
        .QUOT(QUOT), .REM(REM), .neg_flag(neg_flag),
        .zero_flag(zero_flag), .div_zero_flag(div_zero_flag),
        .ovf_flag(ovf_flag)
    );

    assign flags = {neg_flag, zero_flag, div_zero_flag, ovf_flag};

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic [3:0]  f;
        int          cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done cycle must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done cyc=%0d got done=1 required done=0", cyc);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if ({QUOT, REM, flags} !== {mon_e.q, mon_e.r, mon_e.f}) begin
                    fails++;
                    $display("FAIL result cyc=%0d got q=%h r=%h f=%b required q=%h r=%h f=%b",
                             cyc, QUOT, REM, flags, mon_e.q, mon_e.r, mon_e.f);
                end
                checks++;
                if (cyc - mon_e.cyc != mon_e.lat) begin
                    fails++;
                    $display("FAIL latency got %0d required %0d", cyc - mon_e.cyc, mon_e.lat);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h required %h", name, got, want);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] q, input logic [15:0] r, input logic [3:0] f,
                         input int lat, input bit push);
        A = a;
        B = b;
        alu_signed = s;
        start = 1'b1;
        if (push) sb.push_back('{q, r, f, cyc, lat});
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout got pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic go(input logic [31:0] a, input logic [15:0] b, input logic s,
                      input logic [15:0] q, input logic [15:0] r, input logic [3:0] f,
                      input int lat);
        issue(a, b, s, q, r, f, lat, 1'b1);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got stuck required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_out", {28'h0, flags, QUOT, REM}, 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // flags = {neg, zero, div_zero, ovf}
        go(32'h000186A0, 16'h012C, 1'b0, 16'h014D, 16'h0064, 4'b0000, 34);
        go(32'hFFFFFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 4'b1000, 34);
        go(32'h12345678, 16'h0000, 1'b0, 16'hFFFF, 16'h5678, 4'b0010, 2);
        go(32'h80000001, 16'h0000, 1'b1, 16'hFFFF, 16'h0001, 4'b1010, 2);
        go(32'h00010000, 16'h0001, 1'b0, 16'h0000, 16'h0000, 4'b0101, 34);
        go(32'h80000000, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 4'b0101, 34);
        go(32'hFFFF8000, 16'h0001, 1'b1, 16'h8000, 16'h0000, 4'b1000, 34);
        go(32'h00007FFF, 16'h0001, 1'b1, 16'h7FFF, 16'h0000, 4'b0000, 34);
        go(32'h00008000, 16'h0001, 1'b1, 16'h8000, 16'h0000, 4'b1001, 34);
        go(32'h00000007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 4'b1000, 34);
        go(32'hFFFFFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 4'b0000, 34);
        go(32'hFFFE0001, 16'hFFFF, 1'b0, 16'hFFFF, 16'h0000, 4'b0000, 34);
        go(32'hFFFFFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 4'b0001, 34);
        go(32'h00010000, 16'h8000, 1'b1, 16'hFFFE, 16'h0000, 4'b1000, 34);
        go(32'h12345678, 16'h8000, 1'b0, 16'h2468, 16'h5678, 4'b0000, 34);

        repeat (3) @(posedge clk);
        #2;
        chk("hold_out", {28'h0, flags, QUOT, REM}, {28'h0, 4'b0000, 16'h2468, 16'h5678});
        chk("hold_idle", {62'h0, busy, done}, 64'h0);

        // start while busy must be ignored
        issue(32'h00000064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 4'b0000, 34, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #2;
        end
        chk("busy_run", 64'(busy), 64'h1);
        A = 32'hFFFFFFFF;
        B = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        drain();

        // back-to-back: new start in the DONE cycle
        issue(32'h000003E8, 16'h0007, 1'b0, 16'h008E, 16'h0006, 4'b0000, 34, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #2;
            seen = done;
        end
        chk("b2b_done_seen", 64'(seen), 64'h1);
        issue(32'h000186A0, 16'h012C, 1'b0, 16'h014D, 16'h0064, 4'b0000, 34, 1'b1);
        drain();

        // reset in the middle of a run aborts without a done pulse
        issue(32'h12345678, 16'h0003, 1'b0, 16'h0, 16'h0, 4'b0, 34, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #2;
        end
        chk("pre_rst_busy", 64'(busy), 64'h1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_out", {27'h0, done, flags, QUOT, REM}, 64'h0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        go(32'h00000009, 16'h0003, 1'b0, 16'h0003, 16'h0000, 4'b0000, 34);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
